// File: rtl/lut_mult_seq_if.sv
// Handshake bundle for lut_mult_seq: operand request channel and product response channel.
interface lut_mult_seq_if #(
    parameter int WIDTH = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/lut_mult_seq.sv
// Multi-cycle WIDTH x WIDTH multiplier built from 6x6 digit products, LANES digit
// products per cycle, sign-magnitude handling for MUL/MULH/MULHSU/MULHU modes.
module lut_mult_seq #(
    parameter int WIDTH = 64,
    parameter int LANES = 1
) (
    input  logic          clk,
    input  logic          rst,
    lut_mult_seq_if.slave bus
);
    localparam int ND  = (WIDTH + 5) / 6;
    localparam int NC  = (ND + LANES - 1) / LANES;
    localparam int AW  = 12 * ND;
    localparam int PW  = 6 * NC * LANES;
    localparam int IW  = (NC > 1) ? $clog2(NC) : 1;
    localparam int JW  = (ND > 1) ? $clog2(ND) : 1;
    localparam int PRW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg;
    logic [PW-1:0]    a_mag_reg;
    logic [6*ND-1:0]  b_mag_reg;
    logic             neg_reg;
    logic [AW-1:0]    acc_reg;
    logic [IW-1:0]    i_reg;
    logic [JW-1:0]    j_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [PRW-1:0]   product_reg;

    logic             a_sign;
    logic             b_sign;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is the correct magnitude.
    always_comb begin
        a_sign = ((bus.mode == 2'b01) || (bus.mode == 2'b10)) && bus.a[WIDTH-1];
        b_sign = (bus.mode == 2'b01) && bus.b[WIDTH-1];
        a_abs  = a_sign ? -bus.a : bus.a;
        b_abs  = b_sign ? -bus.b : bus.b;
    end

    // Lane L multiplies a-digit (i*LANES+L) by b-digit j; padding digits beyond ND are zero.
    logic [AW-1:0] psum [LANES+1];
    assign psum[0] = '0;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [5:0]    ad;
        logic [5:0]    bd;
        logic [11:0]   pp;
        logic [AW-1:0] term;

        assign ad   = a_mag_reg[6*(int'(i_reg)*LANES + gi) +: 6];
        assign bd   = b_mag_reg[6*int'(j_reg) +: 6];
        assign pp   = 12'(ad) * 12'(bd);
        assign term = AW'(pp) << (6 * (int'(i_reg)*LANES + gi + int'(j_reg)));
        assign psum[gi+1] = psum[gi] + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_mag_reg     <= '0;
            b_mag_reg     <= '0;
            neg_reg       <= 1'b0;
            acc_reg       <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            product_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_mag_reg    <= PW'(a_abs);
                        b_mag_reg    <= (6*ND)'(b_abs);
                        neg_reg      <= a_sign ^ b_sign;
                        acc_reg      <= '0;
                        i_reg        <= '0;
                        j_reg        <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= acc_reg + psum[LANES];
                    if (i_reg == IW'(NC - 1)) begin
                        i_reg <= '0;
                        if (j_reg == JW'(ND - 1)) begin
                            state_reg <= FIX;
                        end else begin
                            j_reg <= j_reg + JW'(1);
                        end
                    end else begin
                        i_reg <= i_reg + IW'(1);
                    end
                end
                FIX: begin
                    product_reg   <= neg_reg ? -acc_reg[PRW-1:0] : acc_reg[PRW-1:0];
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.product   = product_reg;
endmodule

// File: tb/tb_lut_mult_seq.sv
// Bench for lut_mult_seq: three configurations (12/1, 12/2, 64/4) driven through one
// scoreboard; expected products come from a sign-extended behavioural multiply.
module tb_lut_mult_seq;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic [63:0] a_drv     = '0;
    logic [63:0] b_drv     = '0;
    logic [1:0]  mode_drv  = '0;
    logic        out_ready = 1'b1;
    int          sel       = 0;

    lut_mult_seq_if #(.WIDTH(12)) if0 ();
    lut_mult_seq_if #(.WIDTH(12)) if1 ();
    lut_mult_seq_if #(.WIDTH(64)) if2 ();

    assign if0.in_valid  = in_valid && (sel == 0);
    assign if0.a         = a_drv[11:0];
    assign if0.b         = b_drv[11:0];
    assign if0.mode      = mode_drv;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid && (sel == 1);
    assign if1.a         = a_drv[11:0];
    assign if1.b         = b_drv[11:0];
    assign if1.mode      = mode_drv;
    assign if1.out_ready = out_ready;
    assign if2.in_valid  = in_valid && (sel == 2);
    assign if2.a         = a_drv;
    assign if2.b         = b_drv;
    assign if2.mode      = mode_drv;
    assign if2.out_ready = out_ready;

    lut_mult_seq #(.WIDTH(12), .LANES(1)) u_w12_l1 (.clk(clk), .rst(rst), .bus(if0.slave));
    lut_mult_seq #(.WIDTH(12), .LANES(2)) u_w12_l2 (.clk(clk), .rst(rst), .bus(if1.slave));
    lut_mult_seq #(.WIDTH(64), .LANES(4)) u_w64_l4 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic         cur_ov;
    logic         cur_ir;
    logic [127:0] cur_p;

    always_comb begin
        cur_ov = 1'b0;
        cur_ir = 1'b0;
        cur_p  = '0;
        case (sel)
            0: begin cur_ov = if0.out_valid; cur_ir = if0.in_ready; cur_p = 128'(if0.product); end
            1: begin cur_ov = if1.out_valid; cur_ir = if1.in_ready; cur_p = 128'(if1.product); end
            default: begin cur_ov = if2.out_valid; cur_ir = if2.in_ready; cur_p = if2.product; end
        endcase
    end

    typedef struct {
        logic [127:0] p;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int width_of(input int s);
        return (s == 2) ? 64 : 12;
    endfunction

    // Expected latency is ND*ceil(ND/LANES)+1 for each configuration.
    function automatic int lat_of(input int s);
        case (s)
            0:       return 5;
            1:       return 3;
            default: return 34;
        endcase
    endfunction

    function automatic logic [127:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] m);
        logic [63:0]        msk;
        logic signed [129:0] av;
        logic signed [129:0] bv;
        logic signed [129:0] p;
        logic [127:0]       r;
        msk = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
        av  = $signed({66'd0, a & msk});
        bv  = $signed({66'd0, b & msk});
        if (((m == 2'b01) || (m == 2'b10)) && a[w-1]) av = av - (130'sd1 <<< w);
        if ((m == 2'b01) && b[w-1]) bv = bv - (130'sd1 <<< w);
        p = av * bv;
        r = p[127:0];
        if (w < 64) r = r & ((128'(1) << (2*w)) - 128'(1));
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int s, input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                          input bit push);
        int guard;
        guard = 0;
        sel = s;
        #0;
        while (!cur_ir && guard < 300) begin
            tick();
            guard++;
        end
        check("accept_ready", 128'(cur_ir), 128'(1));
        a_drv    = a;
        b_drv    = b;
        mode_drv = m;
        in_valid = 1'b1;
        if (push) sb.push_back('{model(width_of(s), a, b, m), lat_of(s)});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, output logic [127:0] p);
        int   cyc;
        bit   ir_bad;
        exp_t e;
        cyc    = 0;
        ir_bad = 1'b0;
        while (!cur_ov && cyc < 200) begin
            if (cur_ir) ir_bad = 1'b1;
            tick();
            cyc++;
        end
        if (cur_ir) ir_bad = 1'b1;
        p = cur_p;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(0), 128'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 128'(cyc), 128'(e.lat));
            check({tag, "_product"}, cur_p, e.p);
            check({tag, "_in_ready_low"}, 128'(ir_bad), 128'(0));
            $display("txn %s sel=%0d mode=%0d a=%h b=%h product=%h exp=%h lat=%0d",
                     tag, sel, mode_drv, a_drv, b_drv, cur_p, e.p, cyc);
        end
    endtask

    task automatic retire(input string tag);
        tick();
        check({tag, "_retire_ov"}, 128'(cur_ov), 128'(0));
        check({tag, "_retire_ir"}, 128'(cur_ir), 128'(1));
    endtask

    task automatic run_op(input string tag, input int s, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] m, output logic [127:0] p);
        accept(s, a, b, m, 1'b1);
        collect(tag, p);
        retire(tag);
    endtask

    initial begin
        logic [127:0] p;
        logic [127:0] held;
        logic [63:0]  ra;
        logic [63:0]  rb;
        logic [63:0]  msk;
        bit           ov_bad;
        int           w;

        // Reset state on every configuration.
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_out_valid", 128'(cur_ov), 128'(0));
            check("reset_in_ready", 128'(cur_ir), 128'(1));
            check("reset_product", cur_p, 128'(0));
        end
        rst = 1'b0;
        tick();

        // Reset in the second CALC cycle aborts the operation.
        accept(0, 64'hABC, 64'h123, 2'b00, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("midcalc_in_ready", 128'(cur_ir), 128'(1));
        check("midcalc_out_valid", 128'(cur_ov), 128'(0));
        check("midcalc_product", cur_p, 128'(0));
        rst = 1'b0;
        ov_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cur_ov) ov_bad = 1'b1;
        end
        check("midcalc_no_output", 128'(ov_bad), 128'(0));

        // Directed cases with literal expectations.
        run_op("u_fff_fff", 0, 64'hFFF, 64'hFFF, 2'b00, p);
        check("u_fff_fff_lit", p, 128'h0FFE001);
        run_op("s_800_800", 0, 64'h800, 64'h800, 2'b01, p);
        check("s_800_800_lit", p, 128'h0400000);
        run_op("s_fff_001", 0, 64'hFFF, 64'h001, 2'b01, p);
        check("s_fff_001_lit", p, 128'h0FFFFFF);
        run_op("s_000_800", 0, 64'h000, 64'h800, 2'b01, p);
        check("s_000_800_lit", p, 128'h0000000);
        run_op("su_fff_fff", 0, 64'hFFF, 64'hFFF, 2'b10, p);
        check("su_fff_fff_lit", p, 128'h0FFF001);
        run_op("m11_fff_fff", 0, 64'hFFF, 64'hFFF, 2'b11, p);
        check("m11_fff_fff_lit", p, 128'h0FFE001);
        run_op("l2_su_fff_fff", 1, 64'hFFF, 64'hFFF, 2'b10, p);
        check("l2_su_fff_fff_lit", p, 128'h0FFF001);
        run_op("w64_s_min_min", 2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, p);
        check("w64_s_min_min_lit", p, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

        // Backpressure: product held while out_ready is low, new request not taken.
        out_ready = 1'b0;
        accept(0, 64'h9A5, 64'h3C7, 2'b01, 1'b1);
        collect("bp_first", held);
        for (int k = 0; k < 10; k++) begin
            a_drv    = 64'($urandom);
            b_drv    = 64'($urandom);
            in_valid = 1'b1;
            tick();
            check("bp_out_valid", 128'(cur_ov), 128'(1));
            check("bp_product", cur_p, held);
            check("bp_in_ready", 128'(cur_ir), 128'(0));
        end
        a_drv     = 64'h123;
        b_drv     = 64'h456;
        mode_drv  = 2'b00;
        out_ready = 1'b1;
        tick();
        check("bp_release_ov", 128'(cur_ov), 128'(0));
        check("bp_release_ir", 128'(cur_ir), 128'(1));
        sb.push_back('{model(12, 64'h123, 64'h456, 2'b00), lat_of(0)});
        tick();
        in_valid = 1'b0;
        check("bp_new_accept", 128'(cur_ir), 128'(0));
        collect("bp_second", p);
        check("bp_second_lit", p, 128'h04EDC2);
        retire("bp_second");

        // Randomised regression with corner operands at the start of each batch.
        for (int s = 0; s < 3; s++) begin
            w   = width_of(s);
            msk = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 40; n++) begin
                    if (n == 0) begin
                        ra = 64'(1) << (w - 1);
                        rb = 64'(1) << (w - 1);
                    end else if (n == 1) begin
                        ra = msk;
                        rb = 64'(1) << (w - 1);
                    end else if (n == 2) begin
                        ra = msk;
                        rb = msk;
                    end else begin
                        ra = {32'($urandom), 32'($urandom)} & msk;
                        rb = {32'($urandom), 32'($urandom)} & msk;
                    end
                    run_op("rand", s, ra, rb, 2'(m), p);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
